// File: rtl/wav_to_pcm.sv
// Purpose: parse a canonical 44-byte RIFF/WAVE header, then reassemble little-endian PCM samples.
// Latency: a sample is valid the cycle after its last byte is accepted; header and data run at 1 byte/cycle.
// Backpressure: wav_ready drops while a held sample waits on pcm_ready; load and pop may coincide, so there are no bubbles.
module wav_to_pcm #(
    parameter int BIT_DEPTH    = 32,
    parameter int NUM_CHANNELS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           wav_data,
    input  logic                 wav_valid,
    output logic                 wav_ready,
    output logic [BIT_DEPTH-1:0] pcm_data,
    output logic                 pcm_valid,
    input  logic                 pcm_ready,
    output logic [31:0]          sample_rate,
    output logic [31:0]          data_size,
    output logic                 busy,
    output logic                 complete,
    output logic                 hdr_error
);

    localparam int          BYTES     = BIT_DEPTH / 8;
    localparam logic [1:0]  LAST_SEL  = 2'(BYTES - 1);
    localparam logic [31:0] SIZE_MASK = 32'(BYTES - 1);
    localparam logic [15:0] CH16      = 16'(NUM_CHANNELS);
    localparam logic [15:0] BD16      = 16'(BIT_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [5:0]           hdr_cnt;
    logic [1:0]           byte_sel;
    logic                 mismatch;
    logic [31:0]          remaining;
    logic [BIT_DEPTH-1:0] asm_buf;

    logic                 accept;
    logic                 pop;
    logic                 restart;
    logic                 hdr_last;
    logic                 load;
    logic [31:0]          size_final;
    logic [8:0]           hdr_exp;
    logic [BIT_DEPTH-1:0] word_nxt;

    // Expected value of a header byte: bit 8 says whether the byte is checked at all.
    function automatic logic [8:0] hdr_expect(input logic [5:0] idx);
        logic [8:0] e;
        e = 9'h000;
        case (idx)
            6'd0:  e = {1'b1, 8'h52};      // R
            6'd1:  e = {1'b1, 8'h49};      // I
            6'd2:  e = {1'b1, 8'h46};      // F
            6'd3:  e = {1'b1, 8'h46};      // F
            6'd8:  e = {1'b1, 8'h57};      // W
            6'd9:  e = {1'b1, 8'h41};      // A
            6'd10: e = {1'b1, 8'h56};      // V
            6'd11: e = {1'b1, 8'h45};      // E
            6'd12: e = {1'b1, 8'h66};      // f
            6'd13: e = {1'b1, 8'h6d};      // m
            6'd14: e = {1'b1, 8'h74};      // t
            6'd15: e = {1'b1, 8'h20};      // space
            6'd16: e = {1'b1, 8'h10};      // fmt chunk size 16
            6'd17: e = {1'b1, 8'h00};
            6'd18: e = {1'b1, 8'h00};
            6'd19: e = {1'b1, 8'h00};
            6'd20: e = {1'b1, 8'h01};      // PCM format tag
            6'd21: e = {1'b1, 8'h00};
            6'd22: e = {1'b1, CH16[7:0]};
            6'd23: e = {1'b1, CH16[15:8]};
            6'd34: e = {1'b1, BD16[7:0]};
            6'd35: e = {1'b1, BD16[15:8]};
            6'd36: e = {1'b1, 8'h64};      // d
            6'd37: e = {1'b1, 8'h61};      // a
            6'd38: e = {1'b1, 8'h74};      // t
            6'd39: e = {1'b1, 8'h61};      // a
            default: e = 9'h000;
        endcase
        return e;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, byte handshake and state-derived outputs
    always_comb begin
        state_nxt = state;
        wav_ready = 1'b0;
        busy      = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE:   restart = start;
            S_HEADER: begin
                wav_ready = 1'b1;
                busy      = 1'b1;
            end
            S_DATA: begin
                wav_ready = !pcm_valid || pcm_ready;
                busy      = 1'b1;
            end
            S_DONE:   restart = start && !pcm_valid;
            S_ERROR:  restart = start;
            default:  restart = 1'b0;
        endcase

        accept   = wav_valid && wav_ready;
        hdr_last = (state == S_HEADER) && accept && (hdr_cnt == 6'd43);
        load     = (state == S_DATA) && accept && (byte_sel == LAST_SEL);

        if (restart) begin
            state_nxt = S_HEADER;
        end else if (hdr_last) begin
            if (mismatch || ((size_final & SIZE_MASK) != 32'd0)) begin
                state_nxt = S_ERROR;
            end else if (size_final == 32'd0) begin
                state_nxt = S_DONE;
            end else begin
                state_nxt = S_DATA;
            end
        end else if ((state == S_DATA) && accept && (remaining == 32'd1)) begin
            state_nxt = S_DONE;
        end
    end

    // Datapath helpers: sample pop, final data size, header expectation, next assembled word
    always_comb begin
        pop        = pcm_valid && pcm_ready;
        size_final = {wav_data, data_size[23:0]};
        hdr_exp    = hdr_expect(hdr_cnt);
        word_nxt   = asm_buf;
        for (int k = 0; k < BYTES; k++) begin
            if (byte_sel == 2'(k)) begin
                word_nxt[8*k +: 8] = wav_data;
            end
        end
    end

    // Header capture, sample assembly, output register and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt     <= 6'd0;
            byte_sel    <= 2'd0;
            mismatch    <= 1'b0;
            remaining   <= 32'd0;
            asm_buf     <= '0;
            pcm_data    <= '0;
            pcm_valid   <= 1'b0;
            sample_rate <= 32'd0;
            data_size   <= 32'd0;
            complete    <= 1'b0;
            hdr_error   <= 1'b0;
        end else begin
            if (load) begin
                pcm_valid <= 1'b1;
            end else if (pop) begin
                pcm_valid <= 1'b0;
            end

            if (restart) begin
                hdr_cnt   <= 6'd0;
                byte_sel  <= 2'd0;
                mismatch  <= 1'b0;
                complete  <= 1'b0;
                hdr_error <= 1'b0;
            end else begin
                // complete waits for the last sample to leave the output register
                complete <= (state == S_DONE) && !pcm_valid;

                if ((state == S_HEADER) && accept) begin
                    hdr_cnt <= hdr_cnt + 6'd1;
                    if (hdr_exp[8] && (wav_data != hdr_exp[7:0])) begin
                        mismatch <= 1'b1;
                    end
                    case (hdr_cnt)
                        6'd24: sample_rate[7:0]   <= wav_data;
                        6'd25: sample_rate[15:8]  <= wav_data;
                        6'd26: sample_rate[23:16] <= wav_data;
                        6'd27: sample_rate[31:24] <= wav_data;
                        6'd40: data_size[7:0]     <= wav_data;
                        6'd41: data_size[15:8]    <= wav_data;
                        6'd42: data_size[23:16]   <= wav_data;
                        6'd43: data_size[31:24]   <= wav_data;
                        default: ;
                    endcase
                    if (hdr_last) begin
                        remaining <= size_final;
                        hdr_error <= (state_nxt == S_ERROR);
                    end
                end

                if ((state == S_DATA) && accept) begin
                    asm_buf   <= word_nxt;
                    remaining <= remaining - 32'd1;
                    if (load) begin
                        pcm_data <= word_nxt;
                        byte_sel <= 2'd0;
                    end else begin
                        byte_sel <= byte_sel + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wav_to_pcm.sv
`timescale 1ns/1ps
module tb_wav_to_pcm;

    localparam int BD = 32;
    localparam int NC = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    wav_data = 8'h00;
    logic          wav_valid = 1'b0;
    logic          wav_ready;
    logic [BD-1:0] pcm_data;
    logic          pcm_valid;
    logic          pcm_ready = 1'b0;
    logic [31:0]   sample_rate;
    logic [31:0]   data_size;
    logic          busy;
    logic          complete;
    logic          hdr_error;

    wav_to_pcm #(.BIT_DEPTH(BD), .NUM_CHANNELS(NC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .wav_data    (wav_data),
        .wav_valid   (wav_valid),
        .wav_ready   (wav_ready),
        .pcm_data    (pcm_data),
        .pcm_valid   (pcm_valid),
        .pcm_ready   (pcm_ready),
        .sample_rate (sample_rate),
        .data_size   (data_size),
        .busy        (busy),
        .complete    (complete),
        .hdr_error   (hdr_error)
    );

    always #5 clk = ~clk;

    // One test vector: stream description (inputs) plus expected error flag and sample count.
    typedef struct {
        int rate;
        int size;
        int ch;
        int bits;
        int corrupt;   // header byte index overwritten with 'X', -1 for none
        int pat;       // 0: payload 01,02,03..  1: random payload
        int gap;       // percent chance of a wav_valid gap per cycle
        int rmode;     // 0: pcm_ready high, 1: random, 2: held low 10 cycles on first sample
        int exp_err;
        int exp_n;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  stream[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          ready_mode = 0;
    int          stall_left = 0;
    bit          mon_en = 0;
    bit          saw_valid = 0;
    bit          hold_prev = 0;
    logic [31:0] hold_dat = 32'h0;
    vec_t        vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_le(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) stream.push_back(v[8*i +: 8]);
    endtask

    task automatic push_str(input logic [31:0] s);
        for (int i = 3; i >= 0; i--) stream.push_back(s[8*i +: 8]);
    endtask

    // Builds the byte stream and the reference list of samples it should decode to.
    task automatic build(input vec_t v);
        int base;
        stream.delete();
        exp_q.delete();
        push_str("RIFF");
        push_le(36 + v.size, 4);
        push_str("WAVE");
        push_str("fmt ");
        push_le(16, 4);
        push_le(1, 2);
        push_le(v.ch, 2);
        push_le(v.rate, 4);
        push_le(v.rate * v.ch * v.bits / 8, 4);
        push_le(v.ch * v.bits / 8, 2);
        push_le(v.bits, 2);
        push_str("data");
        push_le(v.size, 4);
        for (int i = 0; i < v.size; i++)
            stream.push_back((v.pat == 0) ? 8'(i + 1) : 8'($urandom));
        if (v.corrupt >= 0) stream[v.corrupt] = 8'h58;
        if (v.exp_err == 0) begin
            for (int s = 0; s < v.size / 4; s++) begin
                base = 44 + 4 * s;
                exp_q.push_back({stream[base+3], stream[base+2], stream[base+1], stream[base]});
            end
        end
    endtask

    task automatic drive_stream(input int nbytes, input int gap, output int sent);
        int cyc;
        cyc = 0;
        sent = 0;
        while (sent < nbytes && cyc < 5000) begin
            @(posedge clk);
            #1;
            if (gap > 0 && $urandom_range(99) < gap) begin
                wav_valid = 1'b0;
            end else begin
                wav_valid = 1'b1;
                wav_data  = stream[sent];
            end
            @(negedge clk);
            if (wav_valid && wav_ready) sent++;
            cyc++;
        end
        @(posedge clk);
        #1;
        wav_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wav_ready"}, wav_ready, 0);
        chk({tag, "_pcm_valid"}, pcm_valid, 0);
        chk({tag, "_pcm_data"}, pcm_data, 0);
        chk({tag, "_sample_rate"}, sample_rate, 0);
        chk({tag, "_data_size"}, data_size, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_complete"}, complete, 0);
        chk({tag, "_hdr_error"}, hdr_error, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_case(input int id, input vec_t v);
        int sent;
        int n_acc;
        int cyc;
        logic [31:0] g;
        build(v);
        got_q.delete();
        saw_valid  = 0;
        ready_mode = v.rmode;
        stall_left = 10;
        mon_en     = 1;
        @(negedge clk);
        chk($sformatf("v%0d_idle_ready", id), wav_ready, 0);
        pulse_start();
        chk($sformatf("v%0d_start_ready", id), wav_ready, 1);
        chk($sformatf("v%0d_start_busy", id), busy, 1);
        n_acc = 44 + ((v.exp_err != 0) ? 0 : v.size);
        drive_stream(n_acc, v.gap, sent);
        chk($sformatf("v%0d_bytes_accepted", id), sent, n_acc);
        if (v.exp_err != 0) chk($sformatf("v%0d_err_timing", id), hdr_error, 1);
        cyc = 0;
        while (cyc < 300 && !((v.exp_err != 0) ? (hdr_error == 1'b1)
                                               : (complete == 1'b1 && got_q.size() == v.exp_n))) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk($sformatf("v%0d_hdr_error", id), hdr_error, (v.exp_err != 0));
        chk($sformatf("v%0d_complete", id), complete, (v.exp_err == 0));
        chk($sformatf("v%0d_sample_count", id), got_q.size(), v.exp_n);
        chk($sformatf("v%0d_model_count", id), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            chk($sformatf("v%0d_sample%0d", id, i), g, exp_q[i]);
        end
        chk($sformatf("v%0d_sample_rate", id), sample_rate, v.rate);
        chk($sformatf("v%0d_data_size", id), data_size, v.size);
        chk($sformatf("v%0d_end_ready", id), wav_ready, 0);
        chk($sformatf("v%0d_end_busy", id), busy, 0);
        if (v.exp_err != 0) chk($sformatf("v%0d_no_pcm", id), saw_valid, 0);
    endtask

    // Downstream ready generator, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: pcm_ready = ($urandom_range(3) != 0);
                2: begin
                    if (pcm_valid && got_q.size() == 0 && stall_left > 0) begin
                        pcm_ready = 1'b0;
                        stall_left--;
                    end else begin
                        pcm_ready = 1'b1;
                    end
                end
                default: pcm_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: collects popped samples and checks hold-while-stalled behaviour
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_prev) begin
                chk("pcm_hold_valid", pcm_valid, 1);
                chk("pcm_hold_data", pcm_data, hold_dat);
            end
            if (pcm_valid && !pcm_ready) chk("wav_ready_stall", wav_ready, 0);
            if (pcm_valid) saw_valid = 1;
            if (pcm_valid && pcm_ready) got_q.push_back(pcm_data);
            hold_prev = pcm_valid && !pcm_ready;
            hold_dat  = pcm_data;
        end else begin
            hold_prev = 0;
        end
    end

    initial begin
        int sent;
        //        rate   size ch bits corr pat gap rmode err  n
        vt[0]  = '{48000,   8, 1, 32,  -1, 0,  0, 0,    0,  2};
        vt[1]  = '{48000,   8, 1, 32,  -1, 0,  0, 2,    0,  2};
        vt[2]  = '{48000,   8, 1, 32,   8, 0,  0, 0,    1,  0};
        vt[3]  = '{44100,  16, 1, 32,  -1, 1,  0, 0,    0,  4};
        vt[4]  = '{48000,   8, 2, 32,  -1, 0,  0, 0,    1,  0};
        vt[5]  = '{48000,   6, 1, 32,  -1, 0,  0, 0,    1,  0};
        vt[6]  = '{48000,   0, 1, 32,  -1, 0,  0, 0,    0,  0};
        vt[7]  = '{48000,   8, 1, 32,  -1, 0, 30, 0,    0,  2};
        vt[8]  = '{22050,  12, 1, 32,  30, 1, 25, 1,    0,  3};
        vt[9]  = '{48000,   8, 1, 16,  -1, 0,  0, 0,    1,  0};
        vt[10] = '{96000,  64, 1, 32,  -1, 1, 20, 1,    0, 16};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_case(i, vt[i]);

        // Reset in the middle of a sample, then a clean restart must not see stale bytes
        build(vt[0]);
        got_q.delete();
        ready_mode = 0;
        pulse_start();
        drive_stream(47, 0, sent);
        chk("midreset_bytes_sent", sent, 47);
        mon_en = 0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_case(11, vt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
